// File: rtl/div_unit_if.sv
// Handshake bundle between the execute stage and the iterative divider.
// The master drives the request and flush; the slave returns busy/done/result.
interface div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, rs1, rs2, flush, input busy, done, result);
  modport slave  (input start, op, rs1, rs2, flush, output busy, done, result);
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Works on magnitudes; sign fix-up happens in a single cycle after the last step.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  div_unit_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [5:0]      LAST    = 6'(XLEN-1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [1:0]      op_q;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvsr;
  logic [XLEN:0]   rem;
  logic [5:0]      cnt;
  logic            sign_q;
  logic            sign_r;
  logic [XLEN-1:0] res_q;

  logic            is_signed;
  logic            is_rem;
  logic            accept;
  logic            div0;
  logic            ovf;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic [XLEN-1:0] special_res;
  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] trial;
  logic            q_bit;
  logic [XLEN-1:0] fix_val;
  logic            fix_neg;
  logic [XLEN-1:0] fix_res;

  always_comb begin
    is_signed   = ~bus.op[0];
    is_rem      = bus.op[1];
    accept      = ((state == S_IDLE) || (state == S_DONE)) && bus.start && !bus.flush;
    abs1        = (is_signed && bus.rs1[XLEN-1]) ? -bus.rs1 : bus.rs1;
    abs2        = (is_signed && bus.rs2[XLEN-1]) ? -bus.rs2 : bus.rs2;
    div0        = (bus.rs2 == '0);
    ovf         = is_signed && (bus.rs1 == MIN_INT) && (bus.rs2 == '1);
    special_res = div0 ? (is_rem ? bus.rs1 : '1) : (is_rem ? '0 : MIN_INT);

    // rem < divisor always holds, so one extra bit of headroom is enough for
    // the borrow to be a reliable sign even with divisor 0xFFFFFFFF.
    shifted = {rem, quo[XLEN-1]};
    trial   = shifted - {2'b00, dvsr};
    q_bit   = ~trial[XLEN+1];

    fix_val = op_q[1] ? rem[XLEN-1:0] : quo;
    fix_neg = ~op_q[0] & (op_q[1] ? sign_r : sign_q);
    fix_res = fix_neg ? -fix_val : fix_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= '0;
      quo    <= '0;
      dvsr   <= '0;
      rem    <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      res_q  <= '0;
    end else if (bus.flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            op_q   <= bus.op;
            quo    <= abs1;
            dvsr   <= abs2;
            sign_q <= is_signed & (bus.rs1[XLEN-1] ^ bus.rs2[XLEN-1]);
            sign_r <= is_signed & bus.rs1[XLEN-1];
            cnt    <= '0;
            rem    <= '0;
            if (div0 || ovf) begin
              res_q <= special_res;
              state <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          rem <= q_bit ? trial[XLEN:0] : shifted[XLEN:0];
          quo <= {quo[XLEN-2:0], q_bit};
          cnt <= cnt + 6'd1;
          if (cnt == LAST) state <= S_FIX;
        end
        S_FIX: begin
          res_q <= fix_res;
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state == S_CALC) || (state == S_FIX);
  assign bus.done   = (state == S_DONE);
  assign bus.result = res_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed + random checks of div_unit against an arithmetic reference model.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  div_unit_if #(.XLEN(32)) bus ();
  div_unit #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a; sb = b;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request in the current cycle and wait for done. A nonzero poke
  // pulses a conflicting start that many cycles in, which must be ignored.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int poke);
    int lat;
    logic saw_busy;
    int exp_lat;
    exp_lat = is_special(o, a, b) ? 1 : 34;
    bus.op = o; bus.rs1 = a; bus.rs2 = b; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 1;
    saw_busy = bus.busy;
    while (!bus.done && lat < 100) begin
      if (lat == poke) begin
        bus.start = 1'b1; bus.op = 2'b00; bus.rs1 = 32'd1; bus.rs2 = 32'd1;
      end
      tick();
      bus.start = 1'b0;
      lat++;
      saw_busy |= bus.busy;
    end
    chk({tag, " done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " result"}, bus.result, ref_div(o, a, b));
    chk({tag, " busy seen"}, {31'd0, saw_busy}, {31'd0, exp_lat != 1});
  endtask

  initial begin
    logic [31:0] prev;
    logic [1:0]  o;
    logic [31:0] a, b;
    bus.start = 1'b0; bus.op = 2'b00; bus.rs1 = '0; bus.rs2 = '0; bus.flush = 1'b0;
    #12;
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset result", bus.result, 32'd0);
    rst_n = 1'b1;
    tick();

    do_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 0);
    do_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    tick();
    do_op("divu ffffffff/16", 2'b01, 32'hFFFF_FFFF, 32'h10, 0);
    do_op("remu ffffffff/16", 2'b11, 32'hFFFF_FFFF, 32'h10, 0);
    do_op("divu fffffffe/ffffffff", 2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);
    do_op("remu fffffffe/ffffffff", 2'b11, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);
    tick();
    do_op("div 5/0", 2'b00, 32'd5, 32'd0, 0);
    do_op("remu 5/0", 2'b11, 32'd5, 32'd0, 0);
    do_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    tick();

    // Flush in cycle 10 of a running DIVU, then restart in cycle 12.
    prev = bus.result;
    bus.op = 2'b01; bus.rs1 = 32'd100; bus.rs2 = 32'd7; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush busy", {31'd0, bus.busy}, 32'd0);
    chk("flush done", {31'd0, bus.done}, 32'd0);
    chk("flush result", bus.result, prev);
    tick();
    chk("flush idle done", {31'd0, bus.done}, 32'd0);
    do_op("divu 100/7 poked", 2'b01, 32'd100, 32'd7, 5);

    // Flush and start together: start must lose.
    tick();
    bus.op = 2'b01; bus.rs1 = 32'd9; bus.rs2 = 32'd3; bus.start = 1'b1; bus.flush = 1'b1;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush+start busy", {31'd0, bus.busy}, 32'd0);
    chk("flush+start done", {31'd0, bus.done}, 32'd0);

    // Asynchronous reset mid-operation.
    bus.op = 2'b00; bus.rs1 = 32'd1000; bus.rs2 = 32'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    rst_n = 1'b0;
    #1;
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst done", {31'd0, bus.done}, 32'd0);
    chk("rst result", bus.result, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("post rst done", {31'd0, bus.done}, 32'd0);
    do_op("div 100/-7", 2'b00, 32'd100, 32'hFFFF_FFF9, 0);
    do_op("rem 100/-7 b2b", 2'b10, 32'd100, 32'hFFFF_FFF9, 0);
    tick();

    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = 32'($urandom_range(0, 300));
        default: a = $urandom();
      endcase
      case ($urandom_range(0, 6))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 20));
        3:       b = -32'($urandom_range(1, 20));
        default: b = $urandom();
      endcase
      do_op($sformatf("rand%0d op%0d", i, o), o, a, b, 0);
      if (i % 3 == 0) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 integer divider implementing the RV32M DIV, DIVU, REM and REMU instructions.
- Sits in the execute stage beside the ALU and is fed the same rs1/rs2 operands from the ID/EX register.
- Its result goes to the writeback result mux. The hazard unit holds the pipeline while busy is high.

Parameters:
- XLEN, 32, operand and result width. Only 32 is supported.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; accepted only when busy=0.
- op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- rs1  input  XLEN  dividend; sampled on the accepting edge.
- rs2  input  XLEN  divisor; sampled on the accepting edge.
- flush  input  1  synchronous abort from the branch/trap logic.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  XLEN  quotient or remainder; held until the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, result=0, all internal registers=0.
- Reset deasserted mid-operation: the block restarts in IDLE and no done is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE or DONE with start=1 and flush=0 (accept):
  - Latch op.
  - Signed ops (DIV, REM) latch |rs1| and |rs2|, plus sign_q = rs1[31]^rs2[31] and sign_r = rs1[31].
  - Unsigned ops latch the raw operands with both signs = 0.
  - Clear the 6-bit iteration counter and the 33-bit partial remainder.
  - Special case, rs2==0: result = 0xFFFFFFFF for DIV/DIVU, result = rs1 for REM/REMU; next state is DONE.
  - Special case, DIV/REM with rs1==0x80000000 and rs2==0xFFFFFFFF: result = 0x80000000 for DIV, 0 for REM; next state is DONE.
  - Otherwise next state is CALC.
- CALC, one restoring step per cycle:
  - Shift {rem, dividend} left by 1 and form trial = rem - divisor.
  - If trial is non-negative: rem = trial and the quotient bit is 1. Otherwise rem is unchanged and the quotient bit is 0.
  - After exactly 32 steps (counter reaches 31), go to FIX.
- FIX (one cycle):
  - Select the quotient for DIV/DIVU, the remainder for REM/REMU.
  - Negate (two's complement) when the matching sign is 1: sign_q for DIV, sign_r for REM.
  - Register the value into result; go to DONE.
- DONE (one cycle): done=1; go to IDLE unless a new start is accepted in this cycle.
- busy = 1 in CALC and FIX; 0 in IDLE and DONE.
- Latency, with start high in cycle 0:
  - Normal case: CALC in cycles 1-32, FIX in cycle 33, done=1 in cycle 34.
  - Special cases: done=1 in cycle 1.
- start while busy=1 is ignored, with no queuing. op/rs1/rs2 changes while busy have no effect.
- flush=1 in any state moves to IDLE on the next edge with done=0 and result unchanged.
- flush and start together: flush wins and start is not accepted.
- Back-to-back: start in the DONE cycle is accepted. done still pulses for the finishing operation, and busy rises next cycle.
- Signed results follow RISC-V truncation toward zero; the remainder takes the sign of the dividend.
- The internal subtraction is 33 bits wide so the unsigned divisor 0xFFFFFFFF is handled correctly.

Test Plan:
- Signed DIV and REM: DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> done in cycle 34, result=0xFFFFFFFD (-3). REM with the same operands -> result=0xFFFFFFFF (-1).
- Unsigned: DIVU rs1=0xFFFFFFFF, rs2=0x10 -> result=0x0FFFFFFF. REMU with the same operands -> 0x0000000F. Also DIVU 0xFFFFFFFE / 0xFFFFFFFF -> 0.
- Divide by zero: DIV 5/0 -> done in cycle 1, result=0xFFFFFFFF. REMU 5/0 -> result=5, busy never rises.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF -> result=0x80000000 in cycle 1. REM with the same operands -> 0.
- Flush and ignored start:
  - Start DIVU 100/7, assert flush in cycle 10 -> busy=0 in cycle 11, no done, result unchanged.
  - Start again in cycle 12 -> result=14 in cycle 46.
  - A start pulsed in cycle 5 of a running operation is ignored.
- Reset and back-to-back:
  - Drop rst_n in cycle 20 of an operation -> busy, done and result are 0 immediately. After release, DIV 100/-7 gives 0xFFFFFFF2 (-14).
  - Start REM 100/-7 in that operation's DONE cycle -> done 34 cycles later with result=2.
